// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg
//   Shared definitions for the decode/issue stage and the registered ALU:
//   datapath widths, ALU op codes, RV32I major opcodes and the decoded
//   instruction record passed from alu_decode to alu_issue.
package alu_issue_pkg;

    localparam int XPR_LEN      = 32;
    localparam int ALU_OP_WIDTH = 4;

    typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

    localparam alu_op_t ALU_OP_ADD  = 4'd0;
    localparam alu_op_t ALU_OP_SLL  = 4'd1;
    localparam alu_op_t ALU_OP_XOR  = 4'd4;
    localparam alu_op_t ALU_OP_SRL  = 4'd5;
    localparam alu_op_t ALU_OP_OR   = 4'd6;
    localparam alu_op_t ALU_OP_AND  = 4'd7;
    localparam alu_op_t ALU_OP_SEQ  = 4'd8;
    localparam alu_op_t ALU_OP_SNE  = 4'd9;
    localparam alu_op_t ALU_OP_SUB  = 4'd10;
    localparam alu_op_t ALU_OP_SRA  = 4'd11;
    localparam alu_op_t ALU_OP_SLT  = 4'd12;
    localparam alu_op_t ALU_OP_SGE  = 4'd13;
    localparam alu_op_t ALU_OP_SLTU = 4'd14;
    localparam alu_op_t ALU_OP_SGEU = 4'd15;

    localparam logic [6:0] RV32_OP     = 7'b0110011;
    localparam logic [6:0] RV32_OP_IMM = 7'b0010011;
    localparam logic [6:0] RV32_LUI    = 7'b0110111;
    localparam logic [6:0] RV32_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // Where operand A comes from: register file (with bypass), zero, or PC.
    typedef enum logic [1:0] {
        SRC_A_RF   = 2'd0,
        SRC_A_ZERO = 2'd1,
        SRC_A_PC   = 2'd2
    } src_a_e;

    typedef enum logic {
        SRC_B_RF  = 1'b0,
        SRC_B_IMM = 1'b1
    } src_b_e;

    typedef struct packed {
        alu_op_t            op;
        logic [XPR_LEN-1:0] imm;
        src_a_e             src_a;
        src_b_e             src_b;
        logic               use_rs1;
        logic               use_rs2;
        logic               illegal;
    } dec_t;

    // funct3 -> ALU op; alt selects SUB/SRA (funct7 = 0100000).
    function automatic alu_op_t funct3_to_op(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? ALU_OP_SUB : ALU_OP_ADD;
            3'b001:  op = ALU_OP_SLL;
            3'b010:  op = ALU_OP_SLT;
            3'b011:  op = ALU_OP_SLTU;
            3'b100:  op = ALU_OP_XOR;
            3'b101:  op = alt ? ALU_OP_SRA : ALU_OP_SRL;
            3'b110:  op = ALU_OP_OR;
            default: op = ALU_OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// alu_decode
//   Combinational RV32I integer decoder. Maps an instruction word to ALU op,
//   immediate, operand-source selects, source-used flags and illegal.
//   Ports:
//     instr_i  instruction word
//     dec_o    decoded record (see alu_issue_pkg::dec_t)
module alu_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        dec_o         = '0;
        dec_o.op      = ALU_OP_ADD;
        dec_o.src_a   = SRC_A_RF;
        dec_o.src_b   = SRC_B_RF;
        dec_o.use_rs1 = 1'b0;
        dec_o.use_rs2 = 1'b0;
        dec_o.illegal = 1'b0;
        dec_o.imm     = {{20{instr_i[31]}}, instr_i[31:20]};

        case (opcode)
            RV32_OP: begin
                dec_o.use_rs1 = 1'b1;
                dec_o.use_rs2 = 1'b1;
                if (funct7 == FUNCT7_BASE) begin
                    dec_o.op = funct3_to_op(funct3, 1'b0);
                end else if (funct7 == FUNCT7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec_o.op = funct3_to_op(funct3, 1'b1);
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            RV32_OP_IMM: begin
                dec_o.use_rs1 = 1'b1;
                dec_o.src_b   = SRC_B_IMM;
                if (funct3 == 3'b001) begin
                    dec_o.imm     = {27'd0, instr_i[24:20]};
                    dec_o.op      = ALU_OP_SLL;
                    dec_o.illegal = (funct7 != FUNCT7_BASE);
                end else if (funct3 == 3'b101) begin
                    dec_o.imm     = {27'd0, instr_i[24:20]};
                    dec_o.op      = funct3_to_op(funct3, funct7 == FUNCT7_ALT);
                    dec_o.illegal = (funct7 != FUNCT7_BASE) && (funct7 != FUNCT7_ALT);
                end else begin
                    // ADDI has no SUB form, so funct7 bits are immediate here.
                    dec_o.op = funct3_to_op(funct3, 1'b0);
                end
            end
            RV32_LUI: begin
                dec_o.src_a = SRC_A_ZERO;
                dec_o.src_b = SRC_B_IMM;
                dec_o.imm   = {instr_i[31:12], 12'd0};
            end
            RV32_AUIPC: begin
                dec_o.src_a = SRC_A_PC;
                dec_o.src_b = SRC_B_IMM;
                dec_o.imm   = {instr_i[31:12], 12'd0};
            end
            default: begin
                dec_o.illegal = 1'b1;
            end
        endcase

        // A dropped instruction never reads operands, so it must not stall.
        if (dec_o.illegal) begin
            dec_o.use_rs1 = 1'b0;
            dec_o.use_rs2 = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue
//   Decode-and-issue stage in front of a registered ALU. Accepts RV32I
//   integer instructions on a valid/ready handshake, reads the register
//   file, registers op/operands/enable for the ALU (S1), tracks the
//   destination through the ALU latency (S2) to drive writeback, bypasses
//   the ALU result and stalls one cycle on back-to-back dependencies.
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     in_valid/in_ready/in_instr  instruction handshake
//     in_pc                       PC of in_instr (AUIPC)
//     rf_raddr1/2, rf_rdata1/2    register-file read port
//     alu_op/alu_rs1/alu_rs2      registered ALU command
//     alu_enable                  ALU computes when high
//     alu_rd                      ALU result, one cycle after alu_enable
//     wb_we/wb_addr/wb_data       register-file writeback, aligned with alu_rd
//     illegal                     one-cycle pulse per accepted illegal instruction
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    input  logic [XPR_LEN-1:0]      in_pc,
    output logic [4:0]              rf_raddr1,
    output logic [4:0]              rf_raddr2,
    input  logic [XPR_LEN-1:0]      rf_rdata1,
    input  logic [XPR_LEN-1:0]      rf_rdata2,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic [XPR_LEN-1:0]      alu_rs1,
    output logic [XPR_LEN-1:0]      alu_rs2,
    output logic                    alu_enable,
    input  logic [XPR_LEN-1:0]      alu_rd,
    output logic                    wb_we,
    output logic [4:0]              wb_addr,
    output logic [XPR_LEN-1:0]      wb_data,
    output logic                    illegal
);

    dec_t               dec;
    logic [4:0]         rs1_addr, rs2_addr, rd_addr;
    logic               hazard, accept, issue;
    logic [XPR_LEN-1:0] opnd1, opnd2;

    logic               valid1_q, valid1_d;
    logic [4:0]         rd1_q, rd1_d;
    alu_op_t            op_q, op_d;
    logic [XPR_LEN-1:0] rs1_q, rs1_d;
    logic [XPR_LEN-1:0] rs2_q, rs2_d;
    logic               valid2_q, valid2_d;
    logic [4:0]         rd2_q, rd2_d;
    logic               illegal_q, illegal_d;

    alu_decode u_decode (
        .instr_i (in_instr),
        .dec_o   (dec)
    );

    assign rs1_addr  = in_instr[19:15];
    assign rs2_addr  = in_instr[24:20];
    assign rd_addr   = in_instr[11:7];
    assign rf_raddr1 = rs1_addr;
    assign rf_raddr2 = rs2_addr;

    // The producer in S1 has no result yet; only S2's result can be bypassed.
    assign hazard = in_valid && valid1_q && (rd1_q != 5'd0) &&
                    ((dec.use_rs1 && rs1_addr == rd1_q) ||
                     (dec.use_rs2 && rs2_addr == rd1_q));

    assign in_ready = !hazard;
    assign accept   = in_valid && in_ready;
    assign issue    = accept && !dec.illegal;

    // Checking the source against zero first also excludes rd2 == x0 from bypass.
    always_comb begin
        opnd1 = rf_rdata1;
        if (rs1_addr == 5'd0) begin
            opnd1 = '0;
        end else if (valid2_q && rd2_q == rs1_addr) begin
            opnd1 = alu_rd;
        end

        opnd2 = rf_rdata2;
        if (rs2_addr == 5'd0) begin
            opnd2 = '0;
        end else if (valid2_q && rd2_q == rs2_addr) begin
            opnd2 = alu_rd;
        end
    end

    always_comb begin
        valid1_d  = issue;
        rd1_d     = rd1_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        if (issue) begin
            rd1_d = rd_addr;
            op_d  = dec.op;
            case (dec.src_a)
                SRC_A_ZERO: rs1_d = '0;
                SRC_A_PC:   rs1_d = in_pc;
                default:    rs1_d = opnd1;
            endcase
            rs2_d = (dec.src_b == SRC_B_IMM) ? dec.imm : opnd2;
        end
        valid2_d  = valid1_q;
        rd2_d     = rd1_q;
        illegal_d = accept && dec.illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_q  <= 1'b0;
            rd1_q     <= 5'd0;
            op_q      <= ALU_OP_ADD;
            rs1_q     <= '0;
            rs2_q     <= '0;
            valid2_q  <= 1'b0;
            rd2_q     <= 5'd0;
            illegal_q <= 1'b0;
        end else begin
            valid1_q  <= valid1_d;
            rd1_q     <= rd1_d;
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            valid2_q  <= valid2_d;
            rd2_q     <= rd2_d;
            illegal_q <= illegal_d;
        end
    end

    assign alu_op     = op_q;
    assign alu_rs1    = rs1_q;
    assign alu_rs2    = rs2_q;
    assign alu_enable = valid1_q;

    // A write to x0 still flows through the ALU but is suppressed here.
    assign wb_we   = valid2_q && (rd2_q != 5'd0);
    assign wb_addr = rd2_q;
    assign wb_data = alu_rd;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [31:0]             in_instr;
    logic [XPR_LEN-1:0]      in_pc;
    logic [4:0]              rf_raddr1, rf_raddr2;
    logic [XPR_LEN-1:0]      rf_rdata1, rf_rdata2;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [XPR_LEN-1:0]      alu_rs1, alu_rs2;
    logic                    alu_enable;
    logic [XPR_LEN-1:0]      alu_rd = '0;
    logic                    wb_we;
    logic [4:0]              wb_addr;
    logic [XPR_LEN-1:0]      wb_data;
    logic                    illegal;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .alu_op     (alu_op),
        .alu_rs1    (alu_rs1),
        .alu_rs2    (alu_rs2),
        .alu_enable (alu_enable),
        .alu_rd     (alu_rd),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .illegal    (illegal)
    );

    // ---------------- environment: register file and registered ALU ----------------
    logic [31:0] rf [32] = '{default: '0};

    assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : rf[rf_raddr1];
    assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : rf[rf_raddr2];

    always @(posedge clk) begin
        if (wb_we) rf[wb_addr] <= wb_data;
    end

    function automatic logic [31:0] env_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_OP_ADD:  return a + b;
            ALU_OP_SLL:  return a << b[4:0];
            ALU_OP_XOR:  return a ^ b;
            ALU_OP_SRL:  return a >> b[4:0];
            ALU_OP_OR:   return a | b;
            ALU_OP_AND:  return a & b;
            ALU_OP_SUB:  return a - b;
            ALU_OP_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_OP_SLTU: return {31'd0, a < b};
            default:     return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_enable) alu_rd <= env_alu(alu_op, alu_rs1, alu_rs2);
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- architectural reference model ----------------
    logic [31:0] arch [32];
    logic [31:0] arch_save [32];

    function automatic logic [31:0] isa_arith(input logic [2:0] f3, input logic alt,
                                              input logic [31:0] x, input logic [31:0] y,
                                              input logic [4:0] amt);
        case (f3)
            3'd0:    return alt ? x - y : x + y;
            3'd1:    return x << amt;
            3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3:    return (x < y) ? 32'd1 : 32'd0;
            3'd4:    return x ^ y;
            3'd5:    return alt ? 32'($signed(x) >>> amt) : x >> amt;
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    // Executes one instruction against the architectural registers.
    function automatic void isa_exec(input logic [31:0] ins, input logic [31:0] pc,
                                     output logic legal, output logic [4:0] rd,
                                     output logic [31:0] val,
                                     output logic [4:0] s1, output logic [4:0] s2,
                                     output logic u1, output logic u2);
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a, b, imm;
        f7  = ins[31:25];
        f3  = ins[14:12];
        s1  = ins[19:15];
        s2  = ins[24:20];
        rd  = ins[11:7];
        a   = arch[s1];
        b   = arch[s2];
        imm = {{20{ins[31]}}, ins[31:20]};
        legal = 1'b1;
        u1 = 1'b0;
        u2 = 1'b0;
        val = 32'd0;
        case (ins[6:0])
            7'h33: begin
                u1 = 1'b1;
                u2 = 1'b1;
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                val = isa_arith(f3, f7 == 7'h20, a, b, b[4:0]);
            end
            7'h13: begin
                u1 = 1'b1;
                if (f3 == 3'd1) legal = (f7 == 7'h00);
                if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
                val = isa_arith(f3, f3 == 3'd5 && f7 == 7'h20, a, imm, ins[24:20]);
            end
            7'h37: val = {ins[31:12], 12'd0};
            7'h17: val = pc + {ins[31:12], 12'd0};
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            u1 = 1'b0;
            u2 = 1'b0;
        end
    endfunction

    // Expectations per cycle, ring-indexed by cycle number.
    logic        en_exp  [4];
    logic        ill_exp [4];
    logic        we_exp  [4];
    logic [4:0]  wa_exp  [4];
    logic [31:0] wd_exp  [4];
    int          cyc;
    logic [4:0]  last_rd;
    logic        acc;

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            en_exp[i]  = 1'b0;
            ill_exp[i] = 1'b0;
            we_exp[i]  = 1'b0;
            wa_exp[i]  = 5'd0;
            wd_exp[i]  = 32'd0;
        end
        last_rd = 5'd0;
        acc     = 1'b0;
    endtask

    // One clock cycle with inputs already driven; entered and left at posedge+1.
    task automatic step();
        logic        legal, u1, u2, exp_ready;
        logic [4:0]  rd, s1, s2;
        logic [31:0] val;
        int          k;
        @(negedge clk);
        k = cyc % 4;
        chk("alu_enable", 32'(alu_enable), 32'(en_exp[k]));
        chk("illegal", 32'(illegal), 32'(ill_exp[k]));
        chk("wb_we", 32'(wb_we), 32'(we_exp[k]));
        if (we_exp[k]) begin
            chk("wb_addr", 32'(wb_addr), 32'(wa_exp[k]));
            chk("wb_data", wb_data, wd_exp[k]);
        end
        en_exp[k]  = 1'b0;
        ill_exp[k] = 1'b0;
        we_exp[k]  = 1'b0;
        isa_exec(in_instr, in_pc, legal, rd, val, s1, s2, u1, u2);
        exp_ready = !(in_valid && last_rd != 5'd0 &&
                      ((u1 && s1 == last_rd) || (u2 && s2 == last_rd)));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = in_valid && in_ready;
        last_rd = 5'd0;
        if (acc) begin
            if (legal) begin
                en_exp[(k + 1) % 4] = 1'b1;
                we_exp[(k + 2) % 4] = (rd != 5'd0);
                wa_exp[(k + 2) % 4] = rd;
                wd_exp[(k + 2) % 4] = val;
                if (rd != 5'd0) arch[rd] = val;
                last_rd = rd;
            end else begin
                ill_exp[(k + 1) % 4] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] rand_instr();
        int          k;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [4:0]  rd, r1, r2;
        logic [7:0]  hi;
        k   = $urandom_range(0, 9);
        rd  = 5'($urandom_range(0, 7));
        r1  = 5'($urandom_range(0, 7));
        r2  = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        imm = 12'($urandom);
        hi  = 8'($urandom);
        case (k)
            0, 1, 2, 3: begin
                f7 = 7'h00;
                if ($urandom_range(0, 2) == 0) f7 = 7'h20;
                if ($urandom_range(0, 15) == 0) f7 = 7'h01;
                return {f7, r2, r1, f3, rd, 7'h33};
            end
            4, 5, 6: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    imm[11:5] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
                    if ($urandom_range(0, 15) == 0) imm[11:5] = 7'h08;
                end
                return {imm, r1, f3, rd, 7'h13};
            end
            7:       return {imm, hi, rd, 7'h37};
            8:       return {imm, hi, rd, 7'h17};
            default: return {imm, r1, f3, rd, 7'h03};
        endcase
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ill;
        logic [3:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // Register state entering the table: x1=5, x2=10, others 0.
        tbl[0]  = '{32'h00500093, 32'h0,   1'b0, 4'd0,  32'h0,        32'h5};
        tbl[1]  = '{32'h4040d193, 32'h0,   1'b0, 4'd11, 32'h5,        32'h4};
        tbl[2]  = '{32'h40208233, 32'h0,   1'b0, 4'd10, 32'h5,        32'ha};
        tbl[3]  = '{32'h123452b7, 32'h0,   1'b0, 4'd0,  32'h0,        32'h12345000};
        tbl[4]  = '{32'h00001317, 32'h100, 1'b0, 4'd0,  32'h100,      32'h1000};
        tbl[5]  = '{32'h0000006f, 32'h0,   1'b1, 4'd0,  32'h0,        32'h0};
        tbl[6]  = '{32'h00100013, 32'h0,   1'b0, 4'd0,  32'h0,        32'h1};
        tbl[7]  = '{32'hfff00393, 32'h0,   1'b0, 4'd0,  32'h0,        32'hffffffff};
        tbl[8]  = '{32'h0013b433, 32'h0,   1'b0, 4'd14, 32'hffffffff, 32'h5};
        tbl[9]  = '{32'h4020e233, 32'h0,   1'b1, 4'd0,  32'h0,        32'h0};
        tbl[10] = '{32'h40309493, 32'h0,   1'b1, 4'd0,  32'h0,        32'h0};
        tbl[11] = '{32'h0f00c513, 32'h0,   1'b0, 4'd4,  32'h5,        32'hf0};

        for (int i = 0; i < 32; i++) arch[i] = 32'd0;
        clear_model();
        cyc      = 0;
        in_valid = 1'b1;
        in_instr = 32'h00500093;
        in_pc    = 32'd0;
        rst_n    = 1'b0;

        // Reset held with a valid instruction present.
        repeat (3) begin
            @(negedge clk);
            chk("rst_alu_enable", 32'(alu_enable), 32'd0);
            chk("rst_wb_we", 32'(wb_we), 32'd0);
            chk("rst_illegal", 32'(illegal), 32'd0);
            chk("rst_alu_op", 32'(alu_op), 32'd0);
            chk("rst_alu_rs1", alu_rs1, 32'd0);
            chk("rst_alu_rs2", alu_rs2, 32'd0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back dependency: ADDI x1,x0,5 then ADD x2,x1,x1.
        in_valid = 1'b1;
        in_instr = 32'h00500093;
        step();
        chk("b2b_first_acc", 32'(acc), 32'd1);
        chk("addi_op", 32'(alu_op), 32'd0);
        chk("addi_rs1", alu_rs1, 32'd0);
        chk("addi_rs2", alu_rs2, 32'd5);
        in_instr = 32'h00108133;
        begin
            int stalls;
            stalls = 0;
            for (int t = 0; t < 4; t++) begin
                step();
                if (acc) break;
                stalls++;
            end
            chk("b2b_accepted", 32'(acc), 32'd1);
            chk("b2b_stall_cycles", 32'(stalls), 32'd1);
        end
        chk("bypass_rs1", alu_rs1, 32'd5);
        chk("bypass_rs2", alu_rs2, 32'd5);
        in_valid = 1'b0;
        repeat (3) step();

        // Isolated single instructions from the table.
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_instr = tbl[i].instr;
            in_pc    = tbl[i].pc;
            chk($sformatf("t%0d_raddr1", i), 32'(rf_raddr1), 32'(tbl[i].instr[19:15]));
            chk($sformatf("t%0d_raddr2", i), 32'(rf_raddr2), 32'(tbl[i].instr[24:20]));
            step();
            in_valid = 1'b0;
            chk($sformatf("t%0d_accept", i), 32'(acc), 32'd1);
            chk($sformatf("t%0d_illegal", i), 32'(illegal), 32'(tbl[i].ill));
            chk($sformatf("t%0d_enable", i), 32'(alu_enable), 32'(!tbl[i].ill));
            if (!tbl[i].ill) begin
                chk($sformatf("t%0d_op", i), 32'(alu_op), 32'(tbl[i].op));
                chk($sformatf("t%0d_rs1", i), alu_rs1, tbl[i].rs1);
                chk($sformatf("t%0d_rs2", i), alu_rs2, tbl[i].rs2);
            end
            repeat (3) step();
        end

        // Reset while an instruction sits in the pipeline: no writeback follows.
        arch_save = arch;
        in_valid  = 1'b1;
        in_instr  = 32'h00700493;
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_alu_enable", 32'(alu_enable), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_wb_we", 32'(wb_we), 32'd0);
        end
        arch = arch_save;
        clear_model();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against the architectural model.
        acc = 1'b0;
        for (int n = 0; n < 800; n++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 4) != 0);
                in_instr = rand_instr();
                in_pc    = $urandom;
            end
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();

        for (int i = 1; i < 32; i++) begin
            chk($sformatf("final_x%0d", i), rf[i], arch[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
